// File: rtl/cc_serializer.sv
// cc_serializer: captures a cache line and emits it as a critical-word-first
// R-channel burst, one BEAT_W beat per accepted handshake.
// Optional build macro CC_SERIALIZER_B2B_EN: accept the next line during the
// final beat so consecutive bursts stream with no idle cycle between them.
// Word indexing wraps modulo 2**$clog2(BEATS), so BEATS must be a power of two.
module cc_serializer #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_valid_i,
  output logic                      line_ready_o,
  input  logic [BEAT_W*BEATS-1:0]   line_data_i,
  input  logic [$clog2(BEATS)-1:0]  line_offset_i,
  output logic [BEAT_W-1:0]         inct_rdata_o,
  output logic                      inct_rlast_o,
  output logic                      inct_rvalid_o,
  input  logic                      inct_rready_i
);

  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] buf_q [BEATS];
  logic [CW-1:0]     off_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     idx;
  logic              accept;
  logic              beat_done;
  logic              last_done;

  assign beat_done = inct_rvalid_o & inct_rready_i;
  assign last_done = beat_done & (cnt_q == LAST);
  assign accept    = line_valid_i & line_ready_o;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and line handshake; ready is gated by rst so it stays low
  // for the whole reset pulse even though the state already reads IDLE.
  always_comb begin
    state_d      = state_q;
    line_ready_o = 1'b0;
    if (!rst) begin
      if (state_q == IDLE) line_ready_o = 1'b1;
`ifdef CC_SERIALIZER_B2B_EN
      else if (last_done) line_ready_o = 1'b1;
`endif
    end
    case (state_q)
      IDLE:    if (line_valid_i & line_ready_o) state_d = SEND;
      SEND:    if (last_done) state_d = (line_valid_i & line_ready_o) ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat counter and captured critical-word offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      off_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      off_q <= line_offset_i;
    end else if (beat_done) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Line buffer; contents are only observable through a SEND state, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned w = 0; w < BEATS; w++) begin
        buf_q[w] <= line_data_i[w*BEAT_W +: BEAT_W];
      end
    end
  end

  // R-channel outputs derived purely from registered state.
  always_comb begin
    idx           = off_q + cnt_q;
    inct_rvalid_o = (state_q == SEND);
    inct_rlast_o  = inct_rvalid_o && (cnt_q == LAST);
    inct_rdata_o  = inct_rvalid_o ? buf_q[idx] : '0;
  end

endmodule

// File: tb/tb_cc_serializer.sv
// tb_cc_serializer: directed checks of the cc_serializer burst sequencing.
module tb_cc_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_valid;
  logic         line_ready;
  logic [511:0] line_data;
  logic [2:0]   line_offset;
  logic [63:0]  rdata;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int checks = 0;
  int errors = 0;

  cc_serializer #(.BEAT_W(64), .BEATS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .line_valid_i  (line_valid),
    .line_ready_o  (line_ready),
    .line_data_i   (line_data),
    .line_offset_i (line_offset),
    .inct_rdata_o  (rdata),
    .inct_rlast_o  (rlast),
    .inct_rvalid_o (rvalid),
    .inct_rready_i (rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] x);
    logic [511:0] l;
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = (64'h1111_1111_1111_1111 * 64'(w)) ^ x;
    return l;
  endfunction

  function automatic logic [63:0] wd(input logic [511:0] l, input int w);
    return l[w*64 +: 64];
  endfunction

  task automatic idle_check(input string tag);
    check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    check({tag, "_rlast"},  64'(rlast),  64'd0);
    check({tag, "_rdata"},  rdata,       64'd0);
    check({tag, "_ready"},  64'(line_ready), 64'd1);
  endtask

  // Called at a negedge in IDLE; returns at the negedge where beat 0 is visible.
  task automatic offer(input logic [511:0] l, input int off);
    check("offer_ready", 64'(line_ready), 64'd1);
    line_valid  = 1'b1;
    line_data   = l;
    line_offset = 3'(off);
    @(negedge clk);
    line_valid  = 1'b0;
    line_data   = ~l;
    line_offset = 3'(off + 3);
  endtask

  // Checks nb beats; beats s1/s2 are stalled 3 cycles each. poke offers junk
  // on beats 2..4; chain offers nxt during beat 7.
  task automatic run_burst(input logic [511:0] l, input int off, input int nb,
                           input int s1, input int s2, input bit poke,
                           input bit chain, input logic [511:0] nxt,
                           input int nxt_off, output int cyc);
    int k  = 0;
    int st = 0;
    int kb;
    bit adv;
    cyc = 0;
    while (k < nb) begin
      check("rvalid", 64'(rvalid), 64'd1);
      check($sformatf("rdata_k%0d", k), rdata, wd(l, (off + k) % 8));
      check($sformatf("rlast_k%0d", k), 64'(rlast), 64'(k == 7));
      if (k < 7) check("ready_busy", 64'(line_ready), 64'd0);
      cyc++;
      kb = k;
      if ((k == s1 || k == s2) && st < 3) begin
        rready = 1'b0; st++; adv = 1'b0;
      end else begin
        rready = 1'b1; st = 0; adv = 1'b1; k++;
      end
      line_valid = 1'b0;
      if (poke && kb >= 2 && kb <= 4) begin
        line_valid  = 1'b1;
        line_data   = mk_line(64'hFFFF_0000_FFFF_0000);
        line_offset = 3'd6;
      end
      if (chain && kb == 7 && adv) begin
        line_valid  = 1'b1;
        line_data   = nxt;
        line_offset = 3'(nxt_off);
      end
      @(negedge clk);
    end
    rready = 1'b1;
  endtask

  logic [511:0] la, lb, lc, ld;
  int cyc;

  initial begin
    la = mk_line(64'd0);
    lb = mk_line(64'hDEAD_BEEF_0BAD_F00D);
    lc = mk_line(64'h0123_4567_89AB_CDEF);
    ld = mk_line(64'hCAFE_0000_0000_CAFE);
    rst = 1'b1; line_valid = 1'b0; line_data = '0; line_offset = '0; rready = 1'b1;

    @(negedge clk);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast",  64'(rlast),  64'd0);
    check("rst_rdata",  rdata,       64'd0);
    check("rst_ready",  64'(line_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    idle_check("post_rst");

    // offset 0, rready high
    offer(la, 0);
    run_burst(la, 0, 8, -1, -1, 1'b0, 1'b0, '0, 0, cyc);
    check("t31_cycles", 64'(cyc), 64'd8);
    idle_check("t31_end");

    // offset 5 wrap-around
    offer(la, 5);
    run_burst(la, 5, 8, -1, -1, 1'b0, 1'b0, '0, 0, cyc);
    idle_check("t32_end");

    // offset 2 with stalls on beats 1 and 6
    offer(la, 2);
    run_burst(la, 2, 8, 1, 6, 1'b0, 1'b0, '0, 0, cyc);
    check("t33_send_cycles", 64'(cyc), 64'd14);
    idle_check("t33_end");

    // new line offered mid-burst must be ignored
    offer(lb, 0);
    run_burst(lb, 0, 8, -1, -1, 1'b1, 1'b0, '0, 0, cyc);
    idle_check("t36_end");
    @(negedge clk);
    idle_check("t36_still_idle");

    // back-to-back lines
    offer(la, 0);
    run_burst(la, 0, 8, -1, -1, 1'b0, 1'b1, lb, 3, cyc);
`ifdef CC_SERIALIZER_B2B_EN
    check("t34_no_gap", 64'(rvalid), 64'd1);
`else
    check("t34_gap_rvalid", 64'(rvalid), 64'd0);
    check("t34_gap_ready",  64'(line_ready), 64'd1);
    @(negedge clk);
`endif
    line_valid = 1'b0;
    run_burst(lb, 3, 8, -1, -1, 1'b0, 1'b0, '0, 0, cyc);
    idle_check("t34_end");

    // reset after beat 3 of an offset-7 burst
    offer(lc, 7);
    run_burst(lc, 7, 4, -1, -1, 1'b0, 1'b0, '0, 0, cyc);
    check("t35_beat4_visible", rdata, wd(lc, 3));
    #1 rst = 1'b1;
    #1;
    check("t35_async_rvalid", 64'(rvalid), 64'd0);
    check("t35_async_rlast",  64'(rlast),  64'd0);
    check("t35_async_rdata",  rdata,       64'd0);
    check("t35_async_ready",  64'(line_ready), 64'd0);
    @(negedge clk);
    check("t35_hold_ready",  64'(line_ready), 64'd0);
    check("t35_hold_rvalid", 64'(rvalid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    idle_check("t35_post_rst");
    offer(ld, 1);
    run_burst(ld, 1, 8, -1, -1, 1'b0, 1'b0, '0, 0, cyc);
    check("t35_cycles", 64'(cyc), 64'd8);
    idle_check("t35_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cc_serializer.md
CC_SERIALIZER -- requirements
Module: cc_serializer

Interface
REQ-001 SHALL have parameter BEAT_W, default 64: width of one R beat in bits.
REQ-002 SHALL have parameter BEATS, default 8: beats per cache line; line width is BEAT_W*BEATS (512).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port line_valid_i  input  1  a line is offered for transmission.
REQ-006 SHALL have port line_ready_o  output  1  block accepts the offered line this cycle.
REQ-007 SHALL have port line_data_i  input  512  cache line; word w occupies bits [64w+63:64w].
REQ-008 SHALL have port line_offset_i  input  3  requested (critical) word index, i.e. address bits [5:3].
REQ-009 SHALL have port inct_rdata_o  output  64  R-channel beat data.
REQ-010 SHALL have port inct_rlast_o  output  1  marks the final beat of a burst.
REQ-011 SHALL have port inct_rvalid_o  output  1  beat valid.
REQ-012 SHALL have port inct_rready_i  input  1  receiver accepts the beat.

Function
REQ-013 SHALL implement FSM with states IDLE and SEND; reset state IDLE.
REQ-014 SHALL drive line_ready_o = 1 in IDLE and 0 in SEND, except as extended by REQ-025.
REQ-015 SHALL, on line_valid_i & line_ready_o, capture line_data_i and line_offset_i into internal registers, clear beat counter to 0, and enter SEND on the next edge.
REQ-016 SHALL assert inct_rvalid_o in every SEND cycle and deassert it in IDLE; first beat valid exactly 1 cycle after the accept edge.
REQ-017 SHALL drive beat k (k = 0..7) with captured word (offset + k) mod 8, i.e. critical-word-first with 3-bit wrap-around.
REQ-018 SHALL assert inct_rlast_o only when rvalid is high and beat counter = 7.
REQ-019 SHALL advance beat counter only on inct_rvalid_o & inct_rready_i; 3-bit counter wraps 7 -> 0.
REQ-020 SHALL hold inct_rdata_o, inct_rlast_o, inct_rvalid_o stable while rvalid & !rready (AXI stability rule); rvalid never withdrawn mid-burst.
REQ-021 SHALL return to IDLE on the edge where the beat with rlast is accepted.
REQ-022 SHALL drive inct_rdata_o from registered line buffer and counter only; no combinational path from line_* inputs to inct_* outputs.
REQ-023 SHALL ignore line_valid_i while line_ready_o = 0; offered data need not be held by the block.
REQ-024 SHALL drive inct_rdata_o = 0 in IDLE.

Configuration
REQ-025 SHALL, when macro CC_SERIALIZER_B2B_EN is defined, also assert line_ready_o in SEND during the cycle where counter = 7 & inct_rready_i = 1; an accepted line then starts its beat 0 on the very next cycle with rvalid continuously high (zero-bubble back-to-back bursts).
REQ-026 SHALL, when CC_SERIALIZER_B2B_EN is undefined, assert line_ready_o only in IDLE, giving exactly one idle cycle (rvalid = 0) between consecutive bursts.

Reset
REQ-027 SHALL, on rst assertion regardless of clock, force state IDLE, counter 0, inct_rvalid_o 0, inct_rlast_o 0, inct_rdata_o 0.
REQ-028 SHALL hold line_ready_o = 0 while rst is high and drive it 1 in the first cycle after rst deasserts.
REQ-029 SHALL, on reset mid-burst, discard the remaining beats; no rlast is emitted for the aborted burst and the next accepted line starts at beat 0.
REQ-030 SHALL leave the line buffer contents unspecified after reset; they are not observable.

Verification
REQ-031 Line word w = 0x1111_1111_1111_1111*w, offset 0, rready tied 1 -> beats words 0..7 on 8 consecutive cycles, rlast on word 7, FSM IDLE after.
REQ-032 Same line, offset 5 -> beat order words 5,6,7,0,1,2,3,4; rlast with word 4.
REQ-033 Offset 2, rready low on beats 1 and 6 for 3 cycles each -> rdata/rlast/rvalid held stable through stalls, 14 total SEND cycles, no beat lost or duplicated.
REQ-034 Two lines offered back-to-back, rready 1 -> with CC_SERIALIZER_B2B_EN 16 contiguous valid beats; without, 8 beats, 1 gap cycle, 8 beats.
REQ-035 rst pulsed after beat 3 of offset 7 burst -> rvalid 0 asynchronously, no rlast; next line with offset 1 streams words 1..7,0 normally.
REQ-036 line_valid_i asserted with new data during SEND (B2B off) -> data ignored, current burst unaffected, line_ready_o stays 0 until IDLE.
